// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//   Shares one combinational Hack ALU between NREQ requesters. An idle unit
//   grants the first valid requester at or after the round-robin pointer,
//   latches that requester's operands and drives them to the ALU. It samples
//   the ALU result ALU_LAT cycles later and holds it, tagged with the
//   requester index, until the consumer accepts it. Only one operation is in
//   flight at a time.
//
// Ports
//   clk_i, rst_n_i             clock (rising edge), asynchronous active-low reset
//   req_valid_i / req_ready_o  per-requester request handshake (ready is one-hot)
//   req_x_i, req_y_i           packed operands, requester k at [k*WIDTH +: WIDTH]
//   req_ctl_i                  packed Hack control {zx,nx,zy,ny,f,no}, 6 bits each
//   alu_x_o, alu_y_o, alu_ctl_o  operands and control driven to the shared ALU
//   alu_out_i, alu_zr_i, alu_ng_i  ALU result and flags
//   resp_valid_o / resp_ready_i  result handshake
//   resp_data_o, resp_zr_o, resp_ng_o, resp_id_o  captured result, flags, owner
//   busy_o                     high whenever an operation is in flight
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int ALU_LAT = 1,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NREQ-1:0]       req_valid_i,
    output logic [NREQ-1:0]       req_ready_o,
    input  logic [NREQ*WIDTH-1:0] req_x_i,
    input  logic [NREQ*WIDTH-1:0] req_y_i,
    input  logic [NREQ*6-1:0]     req_ctl_i,
    output logic [WIDTH-1:0]      alu_x_o,
    output logic [WIDTH-1:0]      alu_y_o,
    output logic [5:0]            alu_ctl_o,
    input  logic [WIDTH-1:0]      alu_out_i,
    input  logic                  alu_zr_i,
    input  logic                  alu_ng_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [WIDTH-1:0]      resp_data_o,
    output logic                  resp_zr_o,
    output logic                  resp_ng_o,
    output logic [IDW-1:0]        resp_id_o,
    output logic                  busy_o
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]   x_q, x_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [5:0]         ctl_q, ctl_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               zr_q, zr_d;
    logic               ng_q, ng_d;

    logic [WIDTH-1:0]   x_arr   [NREQ];
    logic [WIDTH-1:0]   y_arr   [NREQ];
    logic [5:0]         ctl_arr [NREQ];

    logic               grant_found;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     cand_idx;
    logic               accept;

    // Unpack the per-requester operand buses and build the one-hot accept.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        assign x_arr[gi]       = req_x_i[gi*WIDTH +: WIDTH];
        assign y_arr[gi]       = req_y_i[gi*WIDTH +: WIDTH];
        assign ctl_arr[gi]     = req_ctl_i[gi*6 +: 6];
        assign req_ready_o[gi] = accept && (grant_idx == IDW'(gi));
    end

    // Round-robin search. Walking offsets from highest to lowest lets the
    // smallest offset from the pointer be the last (winning) assignment.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand_idx = IDW'((int'(ptr_q) + i) % NREQ);
            if (req_valid_i[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Accept is suppressed while reset is asserted so that every output is
    // zero during reset even with requests pending.
    assign accept = rst_n_i && (state_q == ST_IDLE) && grant_found;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        x_d     = x_q;
        y_d     = y_q;
        ctl_d   = ctl_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        zr_d    = zr_q;
        ng_d    = ng_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    state_d = ST_EXEC;
                    id_d    = grant_idx;
                    x_d     = x_arr[grant_idx];
                    y_d     = y_arr[grant_idx];
                    ctl_d   = ctl_arr[grant_idx];
                    cnt_d   = '0;
                end
            end
            ST_EXEC: begin
                if (cnt_q == CW'(ALU_LAT - 1)) begin
                    state_d = ST_RESP;
                    data_d  = alu_out_i;
                    zr_d    = alu_zr_i;
                    ng_d    = alu_ng_i;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                    // Next search starts just past the requester just served.
                    ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            ctl_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            zr_q    <= 1'b0;
            ng_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ctl_q   <= ctl_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            zr_q    <= zr_d;
            ng_q    <= ng_d;
        end
    end

    // The operand registers keep the last operation after returning to IDLE,
    // so the ALU-facing and response outputs are qualified by state.
    assign busy_o       = (state_q != ST_IDLE);
    assign alu_x_o      = busy_o ? x_q   : '0;
    assign alu_y_o      = busy_o ? y_q   : '0;
    assign alu_ctl_o    = busy_o ? ctl_q : '0;
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_data_o  = resp_valid_o ? data_q : '0;
    assign resp_zr_o    = resp_valid_o && zr_q;
    assign resp_ng_o    = resp_valid_o && ng_q;
    assign resp_id_o    = resp_valid_o ? id_q : '0;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_share_arbiter
//   Two arbiters (ALU_LAT=1 and ALU_LAT=3) share one stimulus stream; each
//   has its own Hack ALU model. A transaction-level reference model (pending
//   operation, cycles until result, round-robin pointer) predicts every
//   output each cycle; directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ*6-1:0] req_ctl;
    logic              resp_ready;

    logic [NREQ-1:0] rdy  [2];
    logic [W-1:0]    ax   [2];
    logic [W-1:0]    ay   [2];
    logic [5:0]      actl [2];
    logic [W-1:0]    aout [2];
    logic            azr  [2];
    logic            ang  [2];
    logic            rv   [2];
    logic [W-1:0]    rd   [2];
    logic            rzr  [2];
    logic            rng  [2];
    logic [IDW-1:0]  rid  [2];
    logic            busy [2];

    int vectors = 0;
    int miscompares = 0;

    // Hack ALU: returns {ng, zr, out}
    function automatic logic [17:0] hack(input logic [15:0] x, input logic [15:0] y,
                                         input logic [5:0] c);
        logic [15:0] a, b, o;
        a = c[5] ? 16'h0 : x;
        if (c[4]) a = ~a;
        b = c[3] ? 16'h0 : y;
        if (c[2]) b = ~b;
        o = c[1] ? (a + b) : (a & b);
        if (c[0]) o = ~o;
        return {o[15], (o == 16'h0), o};
    endfunction

    assign {ang[0], azr[0], aout[0]} = hack(ax[0], ay[0], actl[0]);
    assign {ang[1], azr[1], aout[1]} = hack(ax[1], ay[1], actl[1]);

    alu_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .ALU_LAT(1)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(rdy[0]),
        .req_x_i(req_x), .req_y_i(req_y), .req_ctl_i(req_ctl),
        .alu_x_o(ax[0]), .alu_y_o(ay[0]), .alu_ctl_o(actl[0]),
        .alu_out_i(aout[0]), .alu_zr_i(azr[0]), .alu_ng_i(ang[0]),
        .resp_valid_o(rv[0]), .resp_ready_i(resp_ready),
        .resp_data_o(rd[0]), .resp_zr_o(rzr[0]), .resp_ng_o(rng[0]),
        .resp_id_o(rid[0]), .busy_o(busy[0])
    );

    alu_share_arbiter #(.NREQ(NREQ), .WIDTH(W), .ALU_LAT(3)) dut_lat3 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(rdy[1]),
        .req_x_i(req_x), .req_y_i(req_y), .req_ctl_i(req_ctl),
        .alu_x_o(ax[1]), .alu_y_o(ay[1]), .alu_ctl_o(actl[1]),
        .alu_out_i(aout[1]), .alu_zr_i(azr[1]), .alu_ng_i(ang[1]),
        .resp_valid_o(rv[1]), .resp_ready_i(resp_ready),
        .resp_data_o(rd[1]), .resp_zr_o(rzr[1]), .resp_ng_o(rng[1]),
        .resp_id_o(rid[1]), .busy_o(busy[1])
    );

    // ---------------- reference model ----------------
    bit          m_busy [2];
    bit          m_rv   [2];
    int          m_wait [2];
    int          m_ptr  [2];
    int          m_id   [2];
    logic [W-1:0] m_x   [2];
    logic [W-1:0] m_y   [2];
    logic [5:0]  m_ctl  [2];
    int          grants0[$];

    function automatic int lat_of(input int inst);
        return (inst == 0) ? 1 : 3;
    endfunction

    // First valid requester at or after ptr, wrapping; -1 when none.
    function automatic int pick(input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (ptr + k) % NREQ;
            if (req_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_rv[i] = 0; m_wait[i] = 0;
            m_ptr[i] = 0;  m_id[i] = 0;
            m_x[i] = '0;   m_y[i] = '0; m_ctl[i] = '0;
        end
    endtask

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] at %0t: actual=%h required=%h", nm, inst, $time, act, exp);
        end
    endtask

    // Compare every output of both instances against the model.
    task automatic settle();
        #1;
        for (int i = 0; i < 2; i++) begin
            int g;
            logic [NREQ-1:0] exp_rdy;
            logic [17:0] r;
            g = (rst_n && !m_busy[i]) ? pick(m_ptr[i]) : -1;
            exp_rdy = (g < 0) ? '0 : NREQ'(1 << g);
            chk("req_ready", i, 32'(rdy[i]), 32'(exp_rdy));
            chk("busy", i, 32'(busy[i]), 32'(m_busy[i]));
            chk("alu_x", i, 32'(ax[i]), 32'(m_busy[i] ? m_x[i] : '0));
            chk("alu_y", i, 32'(ay[i]), 32'(m_busy[i] ? m_y[i] : '0));
            chk("alu_ctl", i, 32'(actl[i]), 32'(m_busy[i] ? m_ctl[i] : 6'd0));
            chk("resp_valid", i, 32'(rv[i]), 32'(m_rv[i]));
            if (m_rv[i] || !rst_n) begin
                r = m_rv[i] ? hack(m_x[i], m_y[i], m_ctl[i]) : 18'd0;
                chk("resp_data", i, 32'(rd[i]), 32'(r[15:0]));
                chk("resp_zr", i, 32'(rzr[i]), 32'(r[16]));
                chk("resp_ng", i, 32'(rng[i]), 32'(r[17]));
                chk("resp_id", i, 32'(rid[i]), 32'(m_rv[i] ? m_id[i] : 0));
            end
        end
    endtask

    // Clock edge: update the model with the inputs that were stable at it.
    task automatic advance();
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (!m_busy[i]) begin
                    int g;
                    g = pick(m_ptr[i]);
                    if (g >= 0) begin
                        m_busy[i] = 1;
                        m_id[i]   = g;
                        m_x[i]    = req_x[g*W +: W];
                        m_y[i]    = req_y[g*W +: W];
                        m_ctl[i]  = req_ctl[g*6 +: 6];
                        m_wait[i] = lat_of(i);
                        if (i == 0) grants0.push_back(g);
                    end
                end else if (!m_rv[i]) begin
                    m_wait[i]--;
                    if (m_wait[i] == 0) m_rv[i] = 1;
                end else if (resp_ready) begin
                    m_busy[i] = 0;
                    m_rv[i]   = 0;
                    m_ptr[i]  = (m_id[i] + 1) % NREQ;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_operands();
        for (int k = 0; k < NREQ; k++) begin
            req_x[k*W +: W]   = W'($urandom);
            req_y[k*W +: W]   = W'($urandom);
            req_ctl[k*6 +: 6] = 6'($urandom);
        end
    endtask

    task automatic enter_reset();
        rand_operands();
        req_valid  = NREQ'($urandom);
        resp_ready = 1'($urandom);
        rst_n = 1'b0;
        model_reset();
        settle();
    endtask

    task automatic full_reset();
        enter_reset();
        advance();
        settle();
        rst_n = 1'b1;
        req_valid = '0;
        settle();
        advance();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            settle();
            advance();
        end
    endtask

    initial begin
        int n;
        req_valid = '0; req_x = '0; req_y = '0; req_ctl = '0; resp_ready = 1'b0;
        model_reset();
        @(negedge clk);

        // 1: reset with random inputs, then idle after release
        full_reset();
        settle();
        chk("t1_busy_after_release", 0, 32'(busy[0]), 32'd0);

        // 2: single op x=5, y=3, x+y on requester 0
        rand_operands();
        req_x[0 +: W] = 16'd5; req_y[0 +: W] = 16'd3; req_ctl[0 +: 6] = 6'b000010;
        req_valid = 4'b0001; resp_ready = 1'b1;
        settle();
        chk("t2_ready_pulse", 0, 32'(rdy[0]), 32'h1);
        advance();
        req_valid = '0;
        settle();
        chk("t2_ready_gone", 0, 32'(rdy[0]), 32'h0);
        chk("t2_not_yet_valid", 0, 32'(rv[0]), 32'h0);
        advance();
        settle();
        chk("t2_valid", 0, 32'(rv[0]), 32'h1);
        chk("t2_data", 0, 32'(rd[0]), 32'd8);
        chk("t2_zr", 0, 32'(rzr[0]), 32'd0);
        chk("t2_ng", 0, 32'(rng[0]), 32'd0);
        chk("t2_id", 0, 32'(rid[0]), 32'd0);
        advance();

        // 3: contention, all valid continuously
        full_reset();
        grants0.delete();
        req_valid = 4'b1111; resp_ready = 1'b1;
        for (int c = 0; c < 60 && grants0.size() < 5; c++) begin
            rand_operands();
            settle();
            advance();
        end
        chk("t3_grant_count", 0, 32'(grants0.size() >= 5), 32'd1);
        if (grants0.size() >= 5) begin
            for (int k = 0; k < 5; k++)
                chk("t3_grant_order", 0, 32'(grants0[k]), 32'(k % NREQ));
        end

        // 4: wrap search after a grant to 3
        for (int c = 0; c < 60 && grants0[grants0.size()-1] != 3; c++) begin
            settle();
            advance();
        end
        req_valid = 4'b1010;
        n = grants0.size();
        for (int c = 0; c < 60 && grants0.size() < n + 2; c++) begin
            settle();
            advance();
        end
        chk("t4_grant_count", 0, 32'(grants0.size() >= n + 2), 32'd1);
        if (grants0.size() >= n + 2) begin
            chk("t4_first", 0, 32'(grants0[n]), 32'd1);
            chk("t4_second", 0, 32'(grants0[n+1]), 32'd3);
        end

        // 5: backpressure
        full_reset();
        req_valid = 4'b0001; resp_ready = 1'b0;
        settle();
        advance();
        req_valid = 4'b1111;
        settle();
        advance();
        for (int c = 0; c < 5; c++) begin
            rand_operands();
            settle();
            chk("t5_hold_valid", 0, 32'(rv[0]), 32'd1);
            chk("t5_no_grant", 0, 32'(rdy[0]), 32'd0);
            advance();
        end
        resp_ready = 1'b1;
        settle();
        advance();
        settle();
        chk("t5_next_grant", 0, 32'(rdy[0]), 32'h2);
        advance();

        // 6: reset mid-EXEC on the ALU_LAT=3 instance
        full_reset();
        req_valid = 4'b0100; resp_ready = 1'b1;
        settle();
        advance();
        req_valid = '0;
        settle();
        chk("t6_in_exec", 1, 32'(busy[1]), 32'd1);
        advance();
        enter_reset();
        chk("t6_busy_cleared", 1, 32'(busy[1]), 32'd0);
        chk("t6_alu_x_cleared", 1, 32'(ax[1]), 32'd0);
        advance();
        rst_n = 1'b1; req_valid = '0;
        run(6);
        req_valid = 4'b1111;
        settle();
        chk("t6_ptr_zero", 1, 32'(rdy[1]), 32'h1);
        advance();

        // Randomised traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rand_operands();
            req_valid  = NREQ'($urandom) & NREQ'($urandom);
            resp_ready = ($urandom_range(3) != 0);
            if ($urandom_range(399) == 0) begin
                enter_reset();
                advance();
                rst_n = 1'b1;
            end
            settle();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
